// File: rtl/kband_lw_mem_reader.sv
// Avalon-MM block reader feeding an Avalon-ST packet through a small
// credit-controlled FIFO; start/base/length control, busy/done status.
// Ports: clk, reset_n, start, base_addr, length, busy, done,
//   avm_address, avm_chipselect, avm_clken, avm_byteenable,
//   avm_readdata, aso_data, aso_valid, aso_ready,
//   aso_startofpacket, aso_endofpacket.
module kband_lw_mem_reader #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_clken,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic [DATA_W-1:0]     avm_readdata,
  output logic [DATA_W-1:0]     aso_data,
  output logic                  aso_valid,
  input  logic                  aso_ready,
  output logic                  aso_startofpacket,
  output logic                  aso_endofpacket
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued_q;
  logic              inflight_q;
  logic              infl_sop_q;
  logic              infl_eop_q;
  logic              eop_seen_q;

  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_sop;
  logic [FIFO_DEPTH-1:0] fifo_eop;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic issue;
  logic is_last;
  logic is_first;
  logic push;
  logic pop;
  logic eop_hs;
  logic drain_ok;

  assign avm_clken      = 1'b1;
  assign avm_byteenable = '1;

  // Credit: a read cannot be stalled once issued, so reserve a slot
  // for the word still in flight.
  assign issue = (state == FETCH) &&
    ((count + CW'(inflight_q)) < CW'(FIFO_DEPTH));

  assign is_first = (issued_q == '0);
  assign is_last  = (issued_q == len_q - (ADDR_W+1)'(1));

  assign avm_chipselect = issue;
  assign avm_address    = base_q + issued_q[ADDR_W-1:0];

  assign push = inflight_q;
  assign aso_valid = (count != '0);
  assign pop  = aso_valid && aso_ready;
  assign eop_hs = pop && fifo_eop[rd_ptr];

  assign aso_data          = fifo_data[rd_ptr];
  assign aso_startofpacket = aso_valid && fifo_sop[rd_ptr];
  assign aso_endofpacket   = aso_valid && fifo_eop[rd_ptr];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign drain_ok = !inflight_q &&
    (eop_hs || eop_seen_q) &&
    ((count - CW'(pop)) == '0);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) state_nx = DONE;
          else              state_nx = FETCH;
        end
      end
      FETCH: if (issue && is_last) state_nx = DRAIN;
      DRAIN: if (drain_ok) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
      eop_seen_q <= 1'b0;
    end else begin
      state      <= state_nx;
      inflight_q <= issue;
      if (state == IDLE && start && length != '0) begin
        base_q     <= base_addr;
        // anything at or above 2^ADDR_W means the whole memory
        len_q      <= length[ADDR_W] ?
                      {1'b1, {ADDR_W{1'b0}}} : length;
        issued_q   <= '0;
        eop_seen_q <= 1'b0;
      end
      if (issue) begin
        issued_q   <= issued_q + (ADDR_W+1)'(1);
        infl_sop_q <= is_first;
        infl_eop_q <= is_last;
      end
      if (eop_hs) eop_seen_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_sop <= '0;
      fifo_eop <= '0;
    end else if (push) begin
      fifo_sop[wr_ptr] <= infl_sop_q;
      fifo_eop[wr_ptr] <= infl_eop_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr] <= avm_readdata;
  end

endmodule

// File: tb/tb_kband_lw_mem_reader.sv
// Directed bench for kband_lw_mem_reader with a latency-1 memory model
// holding word[i]=i and a negedge monitor logging bus activity.
module tb_kband_lw_mem_reader;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [11:0]   base_addr = '0;
  logic [12:0]   length = '0;
  logic          busy, done;
  logic [11:0]   avm_address;
  logic          avm_chipselect, avm_clken;
  logic [15:0]   avm_byteenable;
  logic [127:0]  avm_readdata = '0;
  logic [127:0]  aso_data;
  logic          aso_valid;
  logic          aso_ready = 1'b1;
  logic          aso_startofpacket, aso_endofpacket;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int max_cnt = 0;

  logic [11:0]  cs_addr[$];
  int           cs_cyc[$];
  logic [127:0] out_data[$];
  bit           out_sop[$];
  bit           out_eop[$];
  int           out_cyc[$];
  int           done_cyc[$];
  bit           done_busy[$];

  kband_lw_mem_reader dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .avm_address(avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_clken(avm_clken),
    .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata),
    .aso_data(aso_data),
    .aso_valid(aso_valid),
    .aso_ready(aso_ready),
    .aso_startofpacket(aso_startofpacket),
    .aso_endofpacket(aso_endofpacket)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    avm_readdata <= avm_chipselect ? {116'd0, avm_address} : '0;
  end

  always @(negedge clk) begin
    if (int'(dut.count) > max_cnt) max_cnt = int'(dut.count);
    if (avm_chipselect) begin
      cs_addr.push_back(avm_address);
      cs_cyc.push_back(cyc);
    end
    if (aso_valid && aso_ready) begin
      out_data.push_back(aso_data);
      out_sop.push_back(aso_startofpacket);
      out_eop.push_back(aso_endofpacket);
      out_cyc.push_back(cyc);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_busy.push_back(busy);
    end
  end

  task automatic clear_logs();
    cs_addr.delete(); cs_cyc.delete();
    out_data.delete(); out_sop.delete();
    out_eop.delete(); out_cyc.delete();
    done_cyc.delete(); done_busy.delete();
    max_cnt = 0;
  endtask

  // rmode 1: random ready (30% high). poke>=0: extra start
  // pulse that many cycles after the job start cycle + 1.
  task automatic run_job(input logic [11:0] b,
                         input logic [12:0] l,
                         input int rmode, input int budget,
                         input int poke, output int t0);
    bit ok = 0;
    clear_logs();
    @(posedge clk); #1;
    base_addr = b; length = l; start = 1'b1; t0 = cyc;
    aso_ready = rmode ? ($urandom_range(0, 9) < 3) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (done_cyc.size() > 0) begin ok = 1; break; end
      start = (n == poke);
      if (n == poke) begin base_addr = 12'h500; length = 13'd3; end
      aso_ready = rmode ? ($urandom_range(0, 9) < 3) : 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0; aso_ready = 1'b1;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL job_timeout base=%h len=%0d got no done, need done", b, l);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk += 9;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b need 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b need 0", done); end
    if (avm_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_cs got %b need 0", avm_chipselect); end
    if (avm_address !== 12'h000) begin n_fail++; $display("FAIL rst_addr got %h need 000", avm_address); end
    if (aso_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b need 0", aso_valid); end
    if (aso_startofpacket !== 1'b0) begin n_fail++; $display("FAIL rst_sop got %b need 0", aso_startofpacket); end
    if (aso_endofpacket !== 1'b0) begin n_fail++; $display("FAIL rst_eop got %b need 0", aso_endofpacket); end
    if (avm_clken !== 1'b1) begin n_fail++; $display("FAIL rst_clken got %b need 1", avm_clken); end
    if (avm_byteenable !== 16'hFFFF) begin n_fail++; $display("FAIL rst_be got %h need ffff", avm_byteenable); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // check a finished in-order job with aso_ready held high
  task automatic check_stream(input string nm, input logic [11:0] b,
                              input int len, input int t0);
    int bad = 0;
    n_chk++;
    if (cs_addr.size() != len || out_data.size() != len) begin
      n_fail++;
      $display("FAIL %s_count got cs=%0d out=%0d need %0d", nm, cs_addr.size(), out_data.size(), len);
    end else begin
      for (int i = 0; i < len; i++) begin
        logic [11:0] a;
        a = b + 12'(i);
        if (cs_addr[i] !== a) bad++;
        if (cs_cyc[i] != t0 + 1 + i) bad++;
        if (out_data[i] !== {116'd0, a}) bad++;
        if (out_cyc[i] != t0 + 3 + i) bad++;
        if (out_sop[i] !== (i == 0)) bad++;
        if (out_eop[i] !== (i == len - 1)) bad++;
      end
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s_stream got %0d bad fields need 0", nm, bad);
      end
    end
    n_chk++;
    if (done_cyc.size() != 1 || done_cyc[0] != t0 + len + 3 || done_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done got n=%0d cyc=%0d need 1 at %0d", nm, done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, t0 + len + 3);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle got busy=%b need 0", nm, busy);
    end
  endtask

  task automatic test_basic();
    int t0;
    run_job(12'h010, 13'd8, 0, 50, -1, t0);
    check_stream("basic", 12'h010, 8, t0);
  endtask

  task automatic test_wrap();
    int t0;
    run_job(12'hFFE, 13'd4, 0, 50, -1, t0);
    check_stream("wrap", 12'hFFE, 4, t0);
  endtask

  task automatic test_back_to_back();
    int t0, d;
    run_job(12'h100, 13'd2, 0, 50, -1, t0);
    check_stream("b2b_a", 12'h100, 2, t0);
    d = done_cyc.size() ? done_cyc[0] : 0;
    run_job(12'h200, 13'd3, 0, 50, -1, t0);
    n_chk++;
    if (t0 != d + 2) begin
      n_fail++;
      $display("FAIL b2b_gap got start=%0d need %0d", t0, d + 2);
    end
    check_stream("b2b_b", 12'h200, 3, t0);
  endtask

  task automatic test_backpressure();
    int t0, bad;
    bad = 0;
    run_job(12'h300, 13'd16, 1, 2000, -1, t0);
    n_chk++;
    if (out_data.size() != 16) begin
      n_fail++;
      $display("FAIL bp_count got %0d need 16", out_data.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (out_data[i] !== {116'd0, 12'h300 + 12'(i)}) bad++;
        if (out_eop[i] !== (i == 15)) bad++;
        if (out_sop[i] !== (i == 0)) bad++;
      end
      if (bad != 0) begin
        n_fail++;
        $display("FAIL bp_order got %0d bad need 0", bad);
      end
    end
    n_chk++;
    if (max_cnt > 4) begin
      n_fail++;
      $display("FAIL bp_fifo_level got %0d need <=4", max_cnt);
    end
  endtask

  task automatic test_zero();
    int t0;
    run_job(12'h055, 13'd0, 0, 20, -1, t0);
    n_chk++;
    if (done_cyc.size() != 1 || done_cyc[0] != t0 + 1 || done_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done got n=%0d need 1 at %0d", done_cyc.size(), t0 + 1);
    end
    n_chk++;
    if (cs_addr.size() != 0 || out_data.size() != 0) begin
      n_fail++;
      $display("FAIL zero_reads got cs=%0d out=%0d need 0", cs_addr.size(), out_data.size());
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_idle got busy=%b need 0", busy);
    end
  endtask

  task automatic test_full(input string nm, input logic [11:0] b,
                           input logic [12:0] l);
    int t0, bad;
    bit seen [4096];
    bad = 0;
    run_job(b, l, 0, 5000, -1, t0);
    n_chk++;
    if (cs_addr.size() != 4096 || out_data.size() != 4096) begin
      n_fail++;
      $display("FAIL %s_count got cs=%0d out=%0d need 4096", nm, cs_addr.size(), out_data.size());
    end else begin
      for (int i = 0; i < 4096; i++) seen[i] = 0;
      for (int i = 0; i < 4096; i++) begin
        if (seen[cs_addr[i]]) bad++;
        seen[cs_addr[i]] = 1;
        if (out_data[i] !== {116'd0, b + 12'(i)}) bad++;
        if (out_eop[i] !== (i == 4095)) bad++;
      end
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s_visit got %0d bad need 0", nm, bad);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    bit hit = 0;
    clear_logs();
    @(posedge clk); #1;
    base_addr = 12'h080; length = 13'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (out_data.size() == 3) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL midrst_pre got %0d words need 3", out_data.size());
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || aso_valid !== 1'b0 || avm_chipselect !== 1'b0 ||
        avm_address !== 12'h000 || done !== 1'b0 ||
        aso_startofpacket !== 1'b0 || aso_endofpacket !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outs got busy=%b v=%b cs=%b a=%h need all 0", busy, aso_valid, avm_chipselect, avm_address);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_logs();
    repeat (6) @(posedge clk);
    #1;
    n_chk++;
    if (out_data.size() != 0 || cs_addr.size() != 0 || done_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_stale got out=%0d cs=%0d need 0", out_data.size(), cs_addr.size());
    end
    run_job(12'h040, 13'd2, 0, 50, -1, t0);
    check_stream("midrst_next", 12'h040, 2, t0);
  endtask

  task automatic test_start_fetch();
    int t0;
    run_job(12'h600, 13'd6, 0, 50, 1, t0);
    repeat (4) @(posedge clk);
    #1;
    check_stream("startfetch", 12'h600, 6, t0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_zero();
    test_full("full", 12'h123, 13'h1000);
    test_full("clamp", 12'h000, 13'h1800);
    test_reset_mid();
    test_start_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
